// File: rtl/irq_pkg.sv
// Shared constants, FSM encoding and helpers for the machine-mode interrupt controller.
package irq_pkg;

    // mip/mie bit positions
    localparam int MEIP = 11;
    localparam int MTIP = 7;
    localparam int MSIP = 3;

    // mcause exception codes
    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    // mcause interrupt flag
    localparam int INTR_BIT = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } irq_state_t;

    // mcause value for an interrupt with the given code
    function automatic logic [31:0] mcause_of(input logic [3:0] code);
        logic [31:0] v;
        v           = '0;
        v[INTR_BIT] = 1'b1;
        v[3:0]      = code;
        return v;
    endfunction

    // mip word built from the three synchronised pending bits
    function automatic logic [31:0] mip_word(input logic meip, input logic mtip, input logic msip);
        logic [31:0] v;
        v       = '0;
        v[MEIP] = meip;
        v[MTIP] = mtip;
        v[MSIP] = msip;
        return v;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for one asynchronous level interrupt line.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // shift the raw line through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: line sync, mip update, priority arbitration and
// request/ack handshake with the trap logic, with handler occupancy tracked until mret.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        sw_irq,
    input  logic [31:0] mie,
    input  logic        mstatus_mie,
    input  logic        trap_ack,
    input  logic        mret,
    output logic [31:0] mip_in,
    output logic        wr_mip,
    output logic        irq_req,
    output logic [31:0] irq_cause
);

    logic       meip, mtip, msip;
    logic [2:0] cur;        // {meip, mtip, msip}
    logic [2:0] shadow;     // last value written to mip
    logic [2:0] elig;       // {MEI, MSI, MTI}, priority order high to low
    logic [2:0] winner;     // one-hot of elig in the same order
    logic [2:0] sel;        // one-hot of the latched request
    logic [3:0] win_code;
    irq_state_t state, state_next;

    // only the three machine interrupt enables are meaningful here
    logic unused_mie;
    assign unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

    irq_sync #(.STAGES(SYNC_STAGES)) u_ext   (.clk(clk), .rst_n(rst_n), .d(ext_irq),   .q(meip));
    irq_sync #(.STAGES(SYNC_STAGES)) u_timer (.clk(clk), .rst_n(rst_n), .d(timer_irq), .q(mtip));
    irq_sync #(.STAGES(SYNC_STAGES)) u_sw    (.clk(clk), .rst_n(rst_n), .d(sw_irq),    .q(msip));

    assign cur  = {meip, mtip, msip};
    assign elig = {meip & mie[MEIP], msip & mie[MSIP], mtip & mie[MTIP]} & {3{mstatus_mie}};

    // fixed priority MEI > MSI > MTI
    always_comb begin
        winner   = 3'b000;
        win_code = CAUSE_MTI;
        if (elig[2]) begin
            winner   = 3'b100;
            win_code = CAUSE_MEI;
        end else if (elig[1]) begin
            winner   = 3'b010;
            win_code = CAUSE_MSI;
        end else if (elig[0]) begin
            winner   = 3'b001;
            win_code = CAUSE_MTI;
        end
    end

    // one mip write per change of the synced pending bits, including a return to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            mip_in <= '0;
            wr_mip <= 1'b0;
        end else if (cur != shadow) begin
            shadow <= cur;
            mip_in <= mip_word(meip, mtip, msip);
            wr_mip <= 1'b1;
        end else begin
            wr_mip <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next state: ack beats withdraw in REQ; HANDLER blocks nesting until mret
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|elig) state_next = REQ;
            REQ: begin
                if (trap_ack)             state_next = HANDLER;
                else if (~|(elig & sel))  state_next = IDLE;
            end
            HANDLER: if (mret) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // registered request and cause; cause is latched only on the IDLE decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_req   <= 1'b0;
            irq_cause <= '0;
            sel       <= '0;
        end else begin
            irq_req <= (state_next == REQ);
            if (state == IDLE && |elig) begin
                sel       <= winner;
                irq_cause <= mcause_of(win_code);
            end
        end
    end

endmodule
